spi_dac_frame_receiver: RTL and testbench

- SPI mode-0 slave that captures the 16-bit DAC frames produced by the sine-wave generator's SPI output (cs_n, sck, mosi).
- Oversamples the three SPI lines with the system clock and extracts the 4 control bits and the 12-bit sample.
- Flags malformed frames.
- Used as the DAC-side model and as an on-chip loopback checker for the signal generator.

---
 rtl/spi_dac_frame_receiver.sv | 151 +++++++++++++++
 tb/tb_spi_dac_frame_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_frame_receiver.sv
// SPI mode-0 slave capturing 16-bit DAC frames {ctrl, data} by oversampling cs_n/sck/mosi.
// Malformed frames are flagged and counted. Good frames update the sample registers.
module spi_dac_frame_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            spi_cs_n,
  input  logic                            spi_sck,
  input  logic                            spi_mosi,
  output logic [DATA_BITS-1:0]            sample_data,
  output logic [FRAME_BITS-DATA_BITS-1:0] sample_ctrl,
  output logic                            sample_valid,
  output logic                            frame_err,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            good_count,
  output logic [CNT_WIDTH-1:0]            err_count
);

  localparam int BCW = $clog2(FRAME_BITS + 2);
  localparam logic [BCW-1:0] BIT_FULL = BCW'(FRAME_BITS);
  localparam logic [BCW-1:0] BIT_OVR  = BCW'(FRAME_BITS + 1);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] RECV      = 2'd2;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q, settle_q;
  logic                   prev_cs_q, prev_sck_q;
  logic                   s_cs, s_sck, s_mosi, settled;
  logic                   sck_rise, cs_fall, cs_rise;

  logic [1:0]              state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [BCW-1:0]          bitcnt_q, bitcnt_d;
  logic                    eval_good_q, eval_good_d;
  logic                    eval_bad_q, eval_bad_d;

  logic [DATA_BITS-1:0]            data_q;
  logic [FRAME_BITS-DATA_BITS-1:0] ctrl_q;
  logic                            valid_q, err_q;
  logic [CNT_WIDTH-1:0]            good_cnt_q, err_cnt_q;

  assign s_cs    = cs_sync_q[SYNC_STAGES-1];
  assign s_sck   = sck_sync_q[SYNC_STAGES-1];
  assign s_mosi  = mosi_sync_q[SYNC_STAGES-1];
  assign settled = settle_q[SYNC_STAGES-1];

  assign sck_rise = s_sck & ~prev_sck_q;
  assign cs_fall  = ~s_cs & prev_cs_q;
  assign cs_rise  = s_cs & ~prev_cs_q;

  // settle_q keeps WAIT_IDLE from trusting the reset value of the cs synchronizer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      prev_cs_q   <= 1'b1;
      prev_sck_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      prev_cs_q   <= s_cs;
      prev_sck_q  <= s_sck;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    eval_good_d = 1'b0;
    eval_bad_d  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (settled && s_cs) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (sck_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], s_mosi};
          if (bitcnt_q != BIT_OVR) bitcnt_d = bitcnt_q + BCW'(1);
        end
        // a bit arriving with the CS edge is counted before the frame is judged
        if (cs_rise) begin
          state_d     = IDLE;
          eval_good_d = (bitcnt_d == BIT_FULL);
          eval_bad_d  = (bitcnt_d != BIT_FULL);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      eval_good_q <= 1'b0;
      eval_bad_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      eval_good_q <= eval_good_d;
      eval_bad_q  <= eval_bad_d;
    end
  end

  // shift_q still holds the judged frame here even if a new frame cleared it this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      valid_q <= eval_good_q;
      err_q   <= eval_bad_q;
      if (eval_good_q) begin
        data_q     <= shift_q[DATA_BITS-1:0];
        ctrl_q     <= shift_q[FRAME_BITS-1:DATA_BITS];
        good_cnt_q <= good_cnt_q + CNT_WIDTH'(1);
      end
      if (eval_bad_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign sample_data  = data_q;
  assign sample_ctrl  = ctrl_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign busy         = (state_q == RECV);
  assign good_count   = good_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Directed bench for spi_dac_frame_receiver with 4-bit counters so wrap/saturation are reachable.
module tb_spi_dac_frame_receiver;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, sck, mosi;
  logic [11:0] sample_data;
  logic [3:0]  sample_ctrl;
  logic        sample_valid, frame_err, busy;
  logic [3:0]  good_count, err_count;

  spi_dac_frame_receiver #(
    .FRAME_BITS(16), .DATA_BITS(12), .SYNC_STAGES(2), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi),
    .sample_data(sample_data), .sample_ctrl(sample_ctrl), .sample_valid(sample_valid),
    .frame_err(frame_err), .busy(busy), .good_count(good_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic        good;
    logic [3:0]  ctrl;
    logic [11:0] data;
  } vec_t;

  vec_t tbl[13];

  int nvec = 0;
  int nmis = 0;
  int pulse_cnt = 0;
  int both_cnt = 0;
  logic [15:0] cap_q[$];
  logic [3:0]  mdl_good = '0;
  logic [3:0]  mdl_err = '0;
  logic        busy_pre, busy_mid;

  always @(negedge clk) begin
    if (sample_valid || frame_err) pulse_cnt++;
    if (sample_valid && frame_err) both_cnt++;
    if (sample_valid) cap_q.push_back({sample_ctrl, sample_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = value[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] value, input int n);
    busy_pre = busy;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    busy_mid = busy;
    send_bits(value, n);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
  endtask

  // Called right after CS is raised at a negedge; the pulse must appear on the 4th negedge.
  task automatic expect_result(input string name, input logic good,
                               input logic [3:0] ctrl, input logic [11:0] data);
    int lat = 0;
    int pulses = 0;
    logic kind = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (sample_valid || frame_err) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          kind = sample_valid;
        end
      end
    end
    if (good) mdl_good = mdl_good + 4'd1;
    else if (mdl_err != 4'hF) mdl_err = mdl_err + 4'd1;
    check({name, ".latency"}, lat, 4);
    check({name, ".pulses"}, pulses, 1);
    check({name, ".kind"}, kind, good);
    check({name, ".ctrl"}, sample_ctrl, ctrl);
    check({name, ".data"}, sample_data, data);
    check({name, ".good_count"}, good_count, mdl_good);
    check({name, ".err_count"}, err_count, mdl_err);
    check({name, ".busy_after"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_good = '0;
    mdl_err = '0;
  endtask

  initial begin
    int snap;
    int qsz;
    tbl[0]  = '{32'h3800, 16, 1'b1, 4'h3, 12'h800};
    tbl[1]  = '{32'h0000, 16, 1'b1, 4'h0, 12'h000};
    tbl[2]  = '{32'h1FFF, 16, 1'b1, 4'h1, 12'hFFF};
    tbl[3]  = '{32'h2555, 16, 1'b1, 4'h2, 12'h555};
    tbl[4]  = '{32'h3AAA, 16, 1'b1, 4'h3, 12'hAAA};
    tbl[5]  = '{32'h4123, 16, 1'b1, 4'h4, 12'h123};
    tbl[6]  = '{32'h5456, 16, 1'b1, 4'h5, 12'h456};
    tbl[7]  = '{32'h6789, 16, 1'b1, 4'h6, 12'h789};
    tbl[8]  = '{32'h7ABC, 16, 1'b1, 4'h7, 12'hABC};
    tbl[9]  = '{32'h8DEF, 16, 1'b1, 4'h8, 12'hDEF};
    tbl[10] = '{32'h90F0, 16, 1'b1, 4'h9, 12'h0F0};
    tbl[11] = '{32'h7FFF, 15, 1'b0, 4'h9, 12'h0F0};
    tbl[12] = '{32'h1FFFF, 17, 1'b0, 4'h9, 12'h0F0};

    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.sample_valid", sample_valid, 1'b0);
    check("rst.frame_err", frame_err, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.data", sample_data, 12'h000);
    check("rst.ctrl", sample_ctrl, 4'h0);
    check("rst.good_count", good_count, 4'h0);
    check("rst.err_count", err_count, 4'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      frame(tbl[v].bits, tbl[v].nbits);
      check($sformatf("vec%0d.busy_pre", v), busy_pre, 1'b0);
      check($sformatf("vec%0d.busy_mid", v), busy_mid, 1'b1);
      expect_result($sformatf("vec%0d", v), tbl[v].good, tbl[v].ctrl, tbl[v].data);
    end

    // reset in the middle of a frame while CS stays low
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'hAB, 8);
    do_reset();
    snap = pulse_cnt;
    send_bits(32'hCD, 8);
    check("abort.busy", busy, 1'b0);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort.no_pulse", pulse_cnt - snap, 0);
    check("abort.data", sample_data, 12'h000);
    check("abort.good_count", good_count, 4'h0);
    check("abort.err_count", err_count, 4'h0);
    frame(32'h1234, 16);
    expect_result("after_abort", 1'b1, 4'h1, 12'h234);

    frame(32'h0, 0);
    expect_result("no_sck", 1'b0, 4'h1, 12'h234);

    snap = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("sck_cs_high.no_pulse", pulse_cnt - snap, 0);
    check("sck_cs_high.busy", busy, 1'b0);
    check("sck_cs_high.err_count", err_count, 4'h1);
    check("sck_cs_high.good_count", good_count, 4'h1);

    // CS high for a single clk between frames
    qsz = cap_q.size();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'h2ABC, 16);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'h5DEF, 16);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    mdl_good = mdl_good + 4'd2;
    check("b2b.captures", cap_q.size() - qsz, 2);
    if (cap_q.size() >= qsz + 2) begin
      check("b2b.first", cap_q[qsz], 16'h2ABC);
      check("b2b.second", cap_q[qsz + 1], 16'h5DEF);
    end
    check("b2b.good_count", good_count, mdl_good);
    check("b2b.err_count", err_count, mdl_err);

    for (int i = 0; i < 17; i++) begin
      frame(32'h0, 0);
      expect_result($sformatf("sat%0d", i), 1'b0, 4'h5, 12'hDEF);
    end
    check("sat.err_count", err_count, 4'hF);

    do_reset();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      frame(32'hC0A5, 16);
      expect_result($sformatf("wrap%0d", i), 1'b1, 4'hC, 12'h0A5);
    end
    check("wrap.good_count", good_count, 4'h1);
    check("wrap.err_count", err_count, 4'h0);

    check("never_both", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
